// File: rtl/riscv_pkg.sv
// Shared RV32I constants: instruction formats, opcodes, loader states.
// Imported by the encoder/loader slice.
package riscv_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] JAL    = 7'h6F;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I format packer: fields + fmt -> 32-bit word.
// With ENCODER_CHECK_EN, illegal tuples become NOP and raise illegal.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
`ifdef ENCODER_CHECK_EN
    output logic        illegal,
`endif
    output logic [31:0] word
);

    logic [31:0] raw;

    // Field placement per format; unknown formats fall back to R.
    always_comb begin
        raw = {funct7, rs2, rs1, funct3, rd, opcode};
        case (fmt)
            FMT_I: raw = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: raw = {imm[12], imm[10:5], rs2, rs1, funct3,
                          imm[4:1], imm[11], opcode};
            FMT_U: raw = {imm[31:12], rd, opcode};
            FMT_J: raw = {imm[20], imm[10:1], imm[11], imm[19:12],
                          rd, opcode};
            default: raw = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

`ifdef ENCODER_CHECK_EN
    // Odd branch/jump offsets and reserved formats are replaced by NOP.
    always_comb begin
        illegal = (fmt > FMT_J)
                | ((fmt == FMT_B) & imm[0])
                | ((fmt == FMT_J) & imm[0]);
        word = illegal ? NOP_WORD : raw;
    end
`else
    assign word = raw;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams field tuples through instr_pack into instruction memory writes.
// Optional illegal-field checking is enabled by ENCODER_CHECK_EN.
module instr_encoder_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     word_count,
    output logic              err_overflow,
    output logic              err_illegal
);

    ld_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       pk_word;
    logic              accept;
    logic              last_slot;

    // Byte-lane bits of the base are dropped when aligning.
    wire unused_base = ^base_addr[1:0];

`ifdef ENCODER_CHECK_EN
    logic pk_illegal;
`endif

    instr_pack u_pack (
        .fmt     (fmt),
        .opcode  (opcode),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct3  (funct3),
        .funct7  (funct7),
        .imm     (imm),
`ifdef ENCODER_CHECK_EN
        .illegal (pk_illegal),
`endif
        .word    (pk_word)
    );

    assign in_ready  = (state == ST_LOAD) && (word_count < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign last_slot = (word_count == CW'(DEPTH - 1));
    assign busy      = (state == ST_LOAD);
    assign done      = (state == ST_DONE);

    // Session FSM, address/count tracking and registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            addr         <= '0;
            word_count   <= '0;
            err_overflow <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        addr         <= {base_addr[ADDR_W-1:2], 2'b00};
                        word_count   <= '0;
                        err_overflow <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= addr;
                        wr_data    <= pk_word;
                        addr       <= addr + ADDR_W'(4);
                        word_count <= word_count + CW'(1);
                        if (in_last) begin
                            state <= ST_DONE;
                        end else if (last_slot) begin
                            state        <= ST_DONE;
                            err_overflow <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ENCODER_CHECK_EN
    // Sticky illegal flag, cleared when a new session starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_illegal <= 1'b0;
        end else if (state != ST_LOAD && start) begin
            err_illegal <= 1'b0;
        end else if (accept && pk_illegal) begin
            err_illegal <= 1'b1;
        end
    end
`else
    assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (DEPTH=4).
// Expectations follow ENCODER_CHECK_EN when it is defined.
module tb_instr_encoder_loader;
    import riscv_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [2:0]        fmt = '0;
    logic [6:0]        opcode = '0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [31:0]       imm = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy, done;
    logic [CW-1:0]     word_count;
    logic              err_overflow, err_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .fmt(fmt),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .word_count(word_count),
        .err_overflow(err_overflow), .err_illegal(err_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] b);
        base_addr = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive one tuple, take one edge, sample #1 later.
    task automatic send(input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im,
                        input logic lst);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im; in_last = lst;
        in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] a,
                          input logic [31:0] d);
        chk({tag, "_en"}, {31'd0, wr_en}, 32'd1);
        chk({tag, "_addr"}, wr_addr, a);
        chk({tag, "_data"}, wr_data, d);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_ovf", {31'd0, err_overflow}, 32'd0);
        chk("rst_ill", {31'd0, err_illegal}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Session 1: addi / add / sw
        do_start(32'h0000_0103);
        chk("s1_busy", {31'd0, busy}, 32'd1);
        chk("s1_ready", {31'd0, in_ready}, 32'd1);
        chk("s1_count0", 32'(word_count), 32'd0);
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        chk_wr("addi", 32'h100, 32'h0050_0093);
        send(FMT_R, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk_wr("add", 32'h104, 32'h0020_81B3);
        send(FMT_S, STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1);
        chk_wr("sw", 32'h108, 32'h0020_A423);
        chk("s1_done", {31'd0, done}, 32'd1);
        chk("s1_busy_off", {31'd0, busy}, 32'd0);
        chk("s1_count", 32'(word_count), 32'd3);
        chk("s1_ready_off", {31'd0, in_ready}, 32'd0);
        chk("s1_ovf", {31'd0, err_overflow}, 32'd0);
        idle_cycle();
        chk("s1_wr_idle", {31'd0, wr_en}, 32'd0);

        // Session 2: beq / lui / jal
        do_start(32'h0000_0200);
        send(FMT_B, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0);
        chk_wr("beq", 32'h200, 32'h0020_8463);
        send(FMT_U, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
             32'h1234_5000, 1'b0);
        chk_wr("lui", 32'h204, 32'h1234_52B7);
        send(FMT_J, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1);
        chk_wr("jal", 32'h208, 32'h0100_00EF);
        chk("s2_done", {31'd0, done}, 32'd1);
        idle_cycle();

        // Session 3: overflow at DEPTH=4, five tuples offered
        do_start(32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            send(FMT_I, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0,
                 32'(i), 1'b0);
            chk("ovf_wr_en", {31'd0, wr_en}, 32'd1);
            chk("ovf_addr", wr_addr, 32'h300 + 32'(4 * i));
        end
        chk("ovf_ready3", {31'd0, in_ready}, 32'd1);
        send(FMT_I, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
        chk_wr("ovf4", 32'h30C, 32'h0030_8093);
        chk("ovf_flag", {31'd0, err_overflow}, 32'd1);
        chk("ovf_done", {31'd0, done}, 32'd1);
        chk("ovf_count", 32'(word_count), 32'd4);
        chk("ovf_ready_off", {31'd0, in_ready}, 32'd0);
        send(FMT_I, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd4, 1'b0);
        chk("ovf_5th_no_wr", {31'd0, wr_en}, 32'd0);
        chk("ovf_count_sat", 32'(word_count), 32'd4);
        idle_cycle();

        // Session 4: async reset mid-session with in_valid held
        do_start(32'h0000_0400);
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        chk("mid_wr", {31'd0, wr_en}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_count", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        chk("arst_hold_wr", {31'd0, wr_en}, 32'd0);
        in_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        do_start(32'h0000_0500);
        send(FMT_R, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        chk_wr("restart", 32'h500, 32'h0020_81B3);
        idle_cycle();

        // Session 5: odd branch offset, reserved format
        do_start(32'h0000_0600);
        send(FMT_B, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0);
`ifdef ENCODER_CHECK_EN
        chk_wr("ill_b", 32'h600, NOP_WORD);
`else
        chk_wr("ill_b", 32'h600, 32'h0020_8363);
`endif
        send(3'd6, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
`ifdef ENCODER_CHECK_EN
        chk_wr("ill_f6", 32'h604, NOP_WORD);
        chk("ill_flag", {31'd0, err_illegal}, 32'd1);
`else
        chk_wr("ill_f6", 32'h604, 32'h0020_81B3);
        chk("ill_flag", {31'd0, err_illegal}, 32'd0);
`endif
        chk("ill_count", 32'(word_count), 32'd2);
        idle_cycle();

        // Session 6: address wrap
        do_start(32'hFFFF_FFFC);
        chk("wrap_ill_clr", {31'd0, err_illegal}, 32'd0);
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        chk_wr("wrap0", 32'hFFFF_FFFC, 32'h0050_0093);
        send(FMT_U, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
             32'h1234_5000, 1'b1);
        chk_wr("wrap1", 32'h0000_0000, 32'h1234_52B7);
        chk("wrap_done", {31'd0, done}, 32'd1);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
